// File: rtl/sysbus_arb_pkg.sv
// Shared types and defaults for the Sysbus master-port arbiter.
package sysbus_arb_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 64;
    localparam int unsigned DEFAULT_TAG_WIDTH  = 13;
    localparam int unsigned DEFAULT_BEATS      = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        WDATA = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

    // The requester that did not win the previous grant.
    function automatic owner_e other_owner(input owner_e o);
        return (o == OWN_IF) ? OWN_MEM : OWN_IF;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant between IF and MEM; ties go to the requester
// that was not granted last time.
module rr_arbiter2
    import sysbus_arb_pkg::*;
(
    input  logic   if_valid,
    input  logic   mem_valid,
    input  owner_e last_grant,
    output logic   grant_valid_c,
    output owner_e grant_owner_c
);

    // Pure combinational grant decision.
    always_comb begin
        grant_valid_c = if_valid | mem_valid;
        grant_owner_c = OWN_IF;
        if (if_valid && mem_valid) begin
            grant_owner_c = other_owner(last_grant);
        end else if (mem_valid) begin
            grant_owner_c = OWN_MEM;
        end
    end

endmodule

// File: rtl/sysbus_arbiter.sv
// Shares the single Sysbus master port between instruction fetch (read-only)
// and data memory (read/write). One line transaction outstanding at a time:
// address phase, then BEATS write-data or read-response beats.
module sysbus_arbiter
    import sysbus_arb_pkg::*;
#(
    parameter int unsigned BUS_DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned BUS_TAG_WIDTH  = DEFAULT_TAG_WIDTH,
    parameter int unsigned BEATS          = DEFAULT_BEATS
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      if_req_valid,
    input  logic [BUS_DATA_WIDTH-1:0] if_req_addr,
    input  logic [BUS_TAG_WIDTH-1:0]  if_req_tag,
    output logic                      if_req_ready,
    output logic                      if_resp_valid,

    input  logic                      mem_req_valid,
    input  logic                      mem_req_we,
    input  logic [BUS_DATA_WIDTH-1:0] mem_req_addr,
    input  logic [BUS_TAG_WIDTH-1:0]  mem_req_tag,
    output logic                      mem_req_ready,
    input  logic [BUS_DATA_WIDTH-1:0] mem_wdata,
    output logic                      mem_wdata_ready,
    output logic                      mem_resp_valid,

    output logic [BUS_DATA_WIDTH-1:0] resp_data,
    output logic                      resp_last,
    output logic                      tag_err,

    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack
);

    localparam int unsigned           CNT_W     = $clog2(BEATS) + 1;
    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);

    arb_state_e                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    owner_e                    last_grant_q, last_grant_d;
    owner_e                    owner_q;
    logic [BUS_DATA_WIDTH-1:0] addr_q;
    logic [BUS_TAG_WIDTH-1:0]  tag_q;
    logic                      we_q;
    logic                      latch_en;
    logic                      tag_err_set;
    logic                      grant_valid_c;
    owner_e                    grant_owner_c;

    rr_arbiter2 u_rr (
        .if_valid      (if_req_valid),
        .mem_valid     (mem_req_valid),
        .last_grant    (last_grant_q),
        .grant_valid_c (grant_valid_c),
        .grant_owner_c (grant_owner_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Beat counter, fairness history, sticky tag error and latched request.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            last_grant_q <= OWN_MEM;
            tag_err      <= 1'b0;
            owner_q      <= OWN_IF;
            addr_q       <= '0;
            tag_q        <= '0;
            we_q         <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            if (tag_err_set) begin
                tag_err <= 1'b1;
            end
            if (latch_en) begin
                owner_q <= grant_owner_c;
                addr_q  <= (grant_owner_c == OWN_IF) ? if_req_addr : mem_req_addr;
                tag_q   <= (grant_owner_c == OWN_IF) ? if_req_tag  : mem_req_tag;
                we_q    <= (grant_owner_c == OWN_MEM) && mem_req_we;
            end
        end
    end

    // Next-state and bus/client handshake decode.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        last_grant_d    = last_grant_q;
        latch_en        = 1'b0;
        tag_err_set     = 1'b0;
        bus_reqcyc      = 1'b0;
        bus_req         = '0;
        bus_reqtag      = '0;
        bus_respack     = 1'b0;
        if_req_ready    = 1'b0;
        mem_req_ready   = 1'b0;
        mem_wdata_ready = 1'b0;
        if_resp_valid   = 1'b0;
        mem_resp_valid  = 1'b0;
        resp_data       = '0;
        resp_last       = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_valid_c) begin
                    latch_en = 1'b1;
                    state_d  = ADDR;
                end
            end

            ADDR: begin
                bus_reqcyc = 1'b1;
                bus_req    = addr_q;
                bus_reqtag = tag_q;
                if (bus_reqack) begin
                    if (owner_q == OWN_IF) begin
                        if_req_ready = 1'b1;
                    end else begin
                        mem_req_ready = 1'b1;
                    end
                    last_grant_d = owner_q;
                    state_d      = we_q ? WDATA : RESP;
                end
            end

            WDATA: begin
                bus_reqcyc = 1'b1;
                bus_req    = mem_wdata;
                bus_reqtag = tag_q;
                if (bus_reqack) begin
                    mem_wdata_ready = 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            RESP: begin
                bus_respack = bus_respcyc;
                if (bus_respcyc) begin
                    if (owner_q == OWN_IF) begin
                        if_resp_valid = 1'b1;
                    end else begin
                        mem_resp_valid = 1'b1;
                    end
                    resp_data = bus_resp;
                    // Mismatched beats are still forwarded; only the flag records it.
                    if (bus_resptag != tag_q) begin
                        tag_err_set = 1'b1;
                    end
                    if (cnt_q == LAST_BEAT) begin
                        resp_last = 1'b1;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter with default parameters (64/13/8).
module tb_sysbus_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req_valid;
    logic [63:0] if_req_addr;
    logic [12:0] if_req_tag;
    logic        if_req_ready;
    logic        if_resp_valid;
    logic        mem_req_valid;
    logic        mem_req_we;
    logic [63:0] mem_req_addr;
    logic [12:0] mem_req_tag;
    logic        mem_req_ready;
    logic [63:0] mem_wdata;
    logic        mem_wdata_ready;
    logic        mem_resp_valid;
    logic [63:0] resp_data;
    logic        resp_last;
    logic        tag_err;
    logic        bus_reqcyc;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_reqack;
    logic        bus_respcyc;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;
    logic        bus_respack;

    int checks = 0;
    int errors = 0;
    logic exp_tag_err = 1'b0;

    sysbus_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .if_req_valid    (if_req_valid),
        .if_req_addr     (if_req_addr),
        .if_req_tag      (if_req_tag),
        .if_req_ready    (if_req_ready),
        .if_resp_valid   (if_resp_valid),
        .mem_req_valid   (mem_req_valid),
        .mem_req_we      (mem_req_we),
        .mem_req_addr    (mem_req_addr),
        .mem_req_tag     (mem_req_tag),
        .mem_req_ready   (mem_req_ready),
        .mem_wdata       (mem_wdata),
        .mem_wdata_ready (mem_wdata_ready),
        .mem_resp_valid  (mem_resp_valid),
        .resp_data       (resp_data),
        .resp_last       (resp_last),
        .tag_err         (tag_err),
        .bus_reqcyc      (bus_reqcyc),
        .bus_req         (bus_req),
        .bus_reqtag      (bus_reqtag),
        .bus_reqack      (bus_reqack),
        .bus_respcyc     (bus_respcyc),
        .bus_resp        (bus_resp),
        .bus_resptag     (bus_resptag),
        .bus_respack     (bus_respack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled just after the falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        if_req_valid  = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        bus_reqack    = 1'b0;
        bus_respcyc   = 1'b0;
        exp_tag_err   = 1'b0;
        cyc();
        cyc();
        #1;
        chk("rst_reqcyc", bus_reqcyc, 1'b0);
        chk("rst_respack", bus_respack, 1'b0);
        chk("rst_if_ready", if_req_ready, 1'b0);
        chk("rst_mem_ready", mem_req_ready, 1'b0);
        chk("rst_wdata_ready", mem_wdata_ready, 1'b0);
        chk("rst_if_resp", if_resp_valid, 1'b0);
        chk("rst_mem_resp", mem_resp_valid, 1'b0);
        chk("rst_last", resp_last, 1'b0);
        chk("rst_tag_err", tag_err, 1'b0);
        reset = 1'b0;
        cyc();
    endtask

    // Entered at the start of an IDLE cycle with requester valid(s) already set.
    // Returns at the start of the IDLE cycle that follows the transaction.
    task automatic run_txn(input bit is_mem, input bit we, input logic [63:0] addr,
                           input logic [12:0] tag, input int ack_delay,
                           input logic [12:0] rtag, input logic [7:0] stall,
                           input bit drop_early);
        logic [63:0] beat;
        int          pulses;
        #1;
        chk("idle_reqcyc", bus_reqcyc, 1'b0);
        chk("idle_respack", bus_respack, 1'b0);
        cyc();
        for (int d = 0; d < ack_delay; d++) begin
            bus_reqack = 1'b0;
            if (drop_early) begin
                if (is_mem) mem_req_valid = 1'b0;
                else        if_req_valid  = 1'b0;
            end
            #1;
            chk("addr_reqcyc", bus_reqcyc, 1'b1);
            chk("addr_req", bus_req, addr);
            chk("addr_tag", bus_reqtag, tag);
            chk("addr_wait_if_ready", if_req_ready, 1'b0);
            chk("addr_wait_mem_ready", mem_req_ready, 1'b0);
            cyc();
        end
        bus_reqack = 1'b1;
        #1;
        chk("ack_req", bus_req, addr);
        chk("ack_tag", bus_reqtag, tag);
        chk("ack_if_ready", if_req_ready, !is_mem);
        chk("ack_mem_ready", mem_req_ready, is_mem);
        cyc();
        bus_reqack = 1'b0;
        if (is_mem) mem_req_valid = 1'b0;
        else        if_req_valid  = 1'b0;

        if (we) begin
            pulses = 0;
            for (int i = 0; i < 8; i++) begin
                beat      = {addr[31:0], 32'(i)};
                mem_wdata = beat;
                if (stall[i]) begin
                    bus_reqack = 1'b0;
                    #1;
                    chk("wr_stall_req", bus_req, beat);
                    chk("wr_stall_ready", mem_wdata_ready, 1'b0);
                    if (mem_wdata_ready) pulses++;
                    cyc();
                end
                bus_reqack = 1'b1;
                #1;
                chk("wr_reqcyc", bus_reqcyc, 1'b1);
                chk("wr_req", bus_req, beat);
                chk("wr_ready", mem_wdata_ready, 1'b1);
                if (mem_wdata_ready) pulses++;
                cyc();
            end
            bus_reqack = 1'b0;
            chk("wr_pulse_count", 64'(pulses), 64'd8);
        end else begin
            for (int i = 0; i < 8; i++) begin
                beat = {addr[31:0] ^ 32'hA5A5_0000, 32'(i)};
                if (stall[i]) begin
                    bus_respcyc = 1'b0;
                    #1;
                    chk("rd_gap_if_valid", if_resp_valid, 1'b0);
                    chk("rd_gap_mem_valid", mem_resp_valid, 1'b0);
                    chk("rd_gap_respack", bus_respack, 1'b0);
                    cyc();
                end
                bus_respcyc = 1'b1;
                bus_resp    = beat;
                bus_resptag = rtag;
                #1;
                chk("rd_if_valid", if_resp_valid, !is_mem);
                chk("rd_mem_valid", mem_resp_valid, is_mem);
                chk("rd_data", resp_data, beat);
                chk("rd_last", resp_last, (i == 7));
                chk("rd_respack", bus_respack, 1'b1);
                chk("rd_tag_err", tag_err, exp_tag_err);
                cyc();
                if (rtag != tag) exp_tag_err = 1'b1;
            end
            bus_respcyc = 1'b0;
        end
    endtask

    initial begin
        reset         = 1'b1;
        if_req_valid  = 1'b0;
        if_req_addr   = '0;
        if_req_tag    = '0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_tag   = '0;
        mem_wdata     = '0;
        bus_reqack    = 1'b0;
        bus_respcyc   = 1'b0;
        bus_resp      = '0;
        bus_resptag   = '0;
        cyc();
        do_reset();

        // IF line read, bus acks after two wait cycles, clean response.
        if_req_valid = 1'b1;
        if_req_addr  = 64'h1000;
        if_req_tag   = 13'h0A;
        run_txn(1'b0, 1'b0, 64'h1000, 13'h0A, 2, 13'h0A, 8'h00, 1'b0);
        #1;
        chk("if_read_done_reqcyc", bus_reqcyc, 1'b0);
        chk("if_read_done_tag_err", tag_err, 1'b0);

        // Simultaneous requests after reset: IF, MEM, IF, MEM.
        do_reset();
        if_req_valid  = 1'b1;
        if_req_addr   = 64'h1000;
        if_req_tag    = 13'h0A;
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b0;
        mem_req_addr  = 64'h3000;
        mem_req_tag   = 13'h15;
        run_txn(1'b0, 1'b0, 64'h1000, 13'h0A, 0, 13'h0A, 8'h00, 1'b0);
        run_txn(1'b1, 1'b0, 64'h3000, 13'h15, 1, 13'h15, 8'h00, 1'b0);
        if_req_valid  = 1'b1;
        mem_req_valid = 1'b1;
        run_txn(1'b0, 1'b0, 64'h1000, 13'h0A, 0, 13'h0A, 8'h00, 1'b0);
        run_txn(1'b1, 1'b0, 64'h3000, 13'h15, 0, 13'h15, 8'h00, 1'b0);

        // MEM line write with the bus stalling beats 3 and 5.
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = 64'h2000;
        mem_req_tag   = 13'h03;
        run_txn(1'b1, 1'b1, 64'h2000, 13'h03, 1, 13'h03, 8'b0010_1000, 1'b0);
        mem_req_we = 1'b0;
        #1;
        chk("wr_done_reqcyc", bus_reqcyc, 1'b0);
        chk("wr_done_wdata_ready", mem_wdata_ready, 1'b0);

        // Read with response gaps and a wrong response tag.
        if_req_valid = 1'b1;
        if_req_addr  = 64'h4000;
        if_req_tag   = 13'h0A;
        run_txn(1'b0, 1'b0, 64'h4000, 13'h0A, 1, 13'h0B, 8'b1010_0110, 1'b0);
        #1;
        chk("tagerr_set", tag_err, 1'b1);
        cyc();
        #1;
        chk("tagerr_sticky", tag_err, 1'b1);
        cyc();

        // MEM drops valid before the address is accepted.
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b0;
        mem_req_addr  = 64'h5000;
        mem_req_tag   = 13'h07;
        run_txn(1'b1, 1'b0, 64'h5000, 13'h07, 2, 13'h07, 8'h00, 1'b1);
        #1;
        chk("drop_idle_reqcyc", bus_reqcyc, 1'b0);
        cyc();
        #1;
        chk("drop_no_regrant", bus_reqcyc, 1'b0);
        chk("drop_tagerr_sticky", tag_err, 1'b1);
        cyc();

        // Reset arrives on response beat 4 of an IF read.
        if_req_valid = 1'b1;
        if_req_addr  = 64'h6000;
        if_req_tag   = 13'h11;
        cyc();
        bus_reqack = 1'b1;
        #1;
        chk("mid_ack_if_ready", if_req_ready, 1'b1);
        cyc();
        bus_reqack   = 1'b0;
        if_req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_respcyc = 1'b1;
            bus_resp    = 64'(i);
            bus_resptag = 13'h11;
            #1;
            chk("mid_beat_valid", if_resp_valid, 1'b1);
            cyc();
        end
        bus_resp = 64'd4;
        reset    = 1'b1;
        cyc();
        reset       = 1'b0;
        exp_tag_err = 1'b0;
        #1;
        chk("mid_rst_reqcyc", bus_reqcyc, 1'b0);
        chk("mid_rst_respack", bus_respack, 1'b0);
        chk("mid_rst_if_resp", if_resp_valid, 1'b0);
        chk("mid_rst_last", resp_last, 1'b0);
        chk("mid_rst_tag_err", tag_err, 1'b0);
        bus_respcyc = 1'b0;
        cyc();
        if_req_valid = 1'b1;
        if_req_addr  = 64'h7000;
        if_req_tag   = 13'h12;
        run_txn(1'b0, 1'b0, 64'h7000, 13'h12, 0, 13'h12, 8'h00, 1'b0);
        #1;
        chk("post_rst_reqcyc", bus_reqcyc, 1'b0);
        chk("post_rst_tag_err", tag_err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
